uart_apb: RTL and testbench

- APB-slave UART peripheral: 8N1 transmitter and receiver with programmable baud prescaler.
- TX and RX FIFOs with programmable thresholds.
- Six-source interrupt block (raw/masked status, mask, write-1-to-clear) driving one `irq` line.
- Sits on the SoC APB bus; `TX`/`RX` go to pads. Benches may loop `TX` back to `RX`.

---
 rtl/uart_apb.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_uart_apb.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb.sv
// APB-slave 8N1 UART with programmable prescaler, 16-byte TX/RX FIFOs and a six-source interrupt block.

// Synchronous byte FIFO with level counter.
// Latency: pushed data is visible at rdat the cycle after the push.
// Backpressure: push while full is dropped (unless popping), pop while empty is ignored.
module uart_fifo #(
    parameter int FAW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic [7:0]     wdat,
    output logic [7:0]     rdat,
    output logic [FAW:0]   level,
    output logic           full,
    output logic           empty
);
    localparam logic [FAW:0] DEPTH = (FAW+1)'(1) << FAW;

    logic [7:0]     mem_q [2**FAW];
    logic [FAW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FAW:0]   level_q, level_d;
    logic           push_ok, pop_ok;

    assign full  = (level_q == DEPTH);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdat  = mem_q[rptr_q];

    always_comb begin
        pop_ok  = pop & ~empty;
        push_ok = push & (~full | pop_ok);
        wptr_d  = push_ok ? wptr_q + (FAW)'(1) : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + (FAW)'(1) : rptr_q;
        level_d = level_q;
        if (push_ok && !pop_ok)
            level_d = level_q + (FAW+1)'(1);
        else if (pop_ok && !push_ok)
            level_d = level_q - (FAW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wptr_q] <= wdat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end
endmodule

// UART peripheral top: APB register file, baud generator, TX/RX FSMs, interrupts.
// Latency: zero-wait-state APB; irq follows RIS/IM by one cycle.
// Backpressure: none on APB; TX writes to a full FIFO and RX overrun bytes are dropped.
module uart_apb #(
    parameter int FAW = 4
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq,
    input  logic        RX,
    output logic        TX
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_st_e;

    logic [11:0]    addr;
    logic           apb_wr, apb_rd;
    logic [15:0]    prescale_q, prescale_d, baud_cnt_q, baud_cnt_d;
    logic [FAW-1:0] txtr_q, txtr_d, rxtr_q, rxtr_d;
    logic           en_q, en_d, irq_q, irq_d, baud_tick;
    logic [5:0]     im_q, im_d, ris_q, ris_d, ris_set, ris_clr;

    logic           txf_pop, txf_full, txf_empty, rxf_push, rxf_full, rxf_empty;
    logic [7:0]     txf_rdat, rxf_rdat;
    logic [FAW:0]   txf_level, rxf_level;

    uart_st_e       tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [3:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]     tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic           tx_q, tx_d, rx_s1_q, rx_s2_q;
    logic           unused_ok;

    assign addr      = PADDR[11:0];
    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign apb_rd    = PSEL & PENABLE & ~PWRITE;
    assign PREADY    = 1'b1;
    assign irq       = irq_q;
    assign TX        = tx_q;
    assign baud_tick = en_q && (baud_cnt_q == prescale_q);
    assign unused_ok = ^{PADDR[31:12], PWDATA[31:16]};

    uart_fifo #(.FAW(FAW)) u_txf (
        .clk(PCLK), .rst_n(PRESETn),
        .push(apb_wr && addr == 12'h000), .pop(txf_pop), .wdat(PWDATA[7:0]),
        .rdat(txf_rdat), .level(txf_level), .full(txf_full), .empty(txf_empty)
    );

    uart_fifo #(.FAW(FAW)) u_rxf (
        .clk(PCLK), .rst_n(PRESETn),
        .push(rxf_push), .pop(apb_rd && addr == 12'h000), .wdat(rx_sh_q),
        .rdat(rxf_rdat), .level(rxf_level), .full(rxf_full), .empty(rxf_empty)
    );

    always_comb begin
        prescale_d = prescale_q;
        txtr_d     = txtr_q;
        rxtr_d     = rxtr_q;
        en_d       = en_q;
        im_d       = im_q;
        ris_clr    = 6'b0;
        if (apb_wr) begin
            case (addr)
                12'h004: prescale_d = PWDATA[15:0];
                12'h008: txtr_d     = PWDATA[FAW-1:0];
                12'h00C: rxtr_d     = PWDATA[FAW-1:0];
                12'h100: en_d       = PWDATA[0];
                12'h208: im_d       = PWDATA[5:0];
                12'h20C: ris_clr    = PWDATA[5:0];
                default: ;
            endcase
        end
        ris_set = {rxf_level > {1'b0, rxtr_q}, rxf_empty, rxf_full,
                   txf_level < {1'b0, txtr_q}, txf_empty, txf_full};
        // A condition still true while being cleared keeps its bit set.
        ris_d      = (ris_q & ~ris_clr) | ris_set;
        irq_d      = |(ris_q & im_q);
        baud_cnt_d = (!en_q || baud_tick) ? 16'd0 : baud_cnt_q + 16'd1;
    end

    always_comb begin
        case (addr)
            12'h000: PRDATA = rxf_empty ? 32'd0 : {24'd0, rxf_rdat};
            12'h004: PRDATA = {16'd0, prescale_q};
            12'h008: PRDATA = {{(32-FAW){1'b0}}, txtr_q};
            12'h00C: PRDATA = {{(32-FAW){1'b0}}, rxtr_q};
            12'h100: PRDATA = {31'd0, en_q};
            12'h200: PRDATA = {26'd0, ris_q};
            12'h204: PRDATA = {26'd0, ris_q & im_q};
            12'h208: PRDATA = {26'd0, im_q};
            default: PRDATA = 32'd0;
        endcase
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        txf_pop  = 1'b0;
        if (!en_q) begin
            tx_st_d  = ST_IDLE;
            tx_cnt_d = 4'd0;
            tx_bit_d = 3'd0;
        end else if (baud_tick) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            case (tx_st_q)
                ST_IDLE: begin
                    tx_cnt_d = 4'd0;
                    if (!txf_empty) begin
                        txf_pop = 1'b1;
                        tx_sh_d = txf_rdat;
                        tx_st_d = ST_START;
                    end
                end
                ST_START: if (tx_cnt_q == 4'd15) begin
                    tx_st_d  = ST_DATA;
                    tx_bit_d = 3'd0;
                end
                ST_DATA: if (tx_cnt_q == 4'd15) begin
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7)
                        tx_st_d = ST_STOP;
                end
                default: if (tx_cnt_q == 4'd15) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!txf_empty) begin
                        txf_pop = 1'b1;
                        tx_sh_d = txf_rdat;
                        tx_st_d = ST_START;
                    end else begin
                        tx_st_d = ST_IDLE;
                    end
                end
            endcase
        end
        case (tx_st_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_sh_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rxf_push = 1'b0;
        if (!en_q) begin
            rx_st_d  = ST_IDLE;
            rx_cnt_d = 4'd0;
            rx_bit_d = 3'd0;
        end else if (baud_tick) begin
            rx_cnt_d = rx_cnt_q + 4'd1;
            case (rx_st_q)
                ST_IDLE: begin
                    rx_cnt_d = 4'd0;
                    if (!rx_s2_q)
                        rx_st_d = ST_START;
                end
                ST_START: if (rx_cnt_q == 4'd7) begin
                    // Mid-start-bit recheck; a high line here was a glitch.
                    rx_cnt_d = 4'd0;
                    rx_bit_d = 3'd0;
                    rx_st_d  = rx_s2_q ? ST_IDLE : ST_DATA;
                end
                ST_DATA: if (rx_cnt_q == 4'd15) begin
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7)
                        rx_st_d = ST_STOP;
                end
                default: if (rx_cnt_q == 4'd15) begin
                    rxf_push = rx_s2_q;
                    rx_st_d  = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            prescale_q <= '0;
            txtr_q     <= '0;
            rxtr_q     <= '0;
            en_q       <= 1'b0;
            im_q       <= '0;
            ris_q      <= '0;
            irq_q      <= 1'b0;
            baud_cnt_q <= '0;
            tx_st_q    <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_q       <= 1'b1;
            rx_st_q    <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
        end else begin
            prescale_q <= prescale_d;
            txtr_q     <= txtr_d;
            rxtr_q     <= rxtr_d;
            en_q       <= en_d;
            im_q       <= im_d;
            ris_q      <= ris_d;
            irq_q      <= irq_d;
            baud_cnt_q <= baud_cnt_d;
            tx_st_q    <= tx_st_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_q       <= tx_d;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_s1_q    <= RX;
            rx_s2_q    <= rx_s1_q;
        end
    end
endmodule

// File: tb/tb_uart_apb.sv
// Scoreboard bench for uart_apb: directed APB traffic with TX looped to RX or RX driven by hand.
module tb_uart_apb;
    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, irq, TX, rx_line;
    logic        loop_en, rx_man;

    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mask_q[$];
    string       name_q[$];
    logic        chk_active = 1'b0;
    logic [31:0] mon_e, mon_m;
    string       mon_n;

    always #5 PCLK = ~PCLK;
    assign rx_line = loop_en ? TX : rx_man;

    uart_apb dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .irq(irq), .RX(rx_line), .TX(TX)
    );

    // Monitor: every checked read's access phase pops one expected entry.
    always @(negedge PCLK) begin
        if (chk_active && PSEL && PENABLE && !PWRITE) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty: read 0x%08h with nothing expected", PRDATA);
            end else begin
                mon_e = exp_q.pop_front();
                mon_m = mask_q.pop_front();
                mon_n = name_q.pop_front();
                if ((PRDATA & mon_m) !== mon_e) begin
                    miscompares++;
                    $display("FAIL %s: got 0x%08h want 0x%08h (mask 0x%08h)",
                             mon_n, PRDATA & mon_m, mon_e, mon_m);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge PCLK);
    endtask

    task automatic chk(input string n, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic check_read(input logic [31:0] a, input logic [31:0] exp,
                              input logic [31:0] mask, input string n);
        logic [31:0] d;
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        name_q.push_back(n);
        chk_active = 1'b1;
        apb_read(a, d);
        chk_active = 1'b0;
    endtask

    task automatic poll(input logic [31:0] a, input logic [31:0] mask,
                        input int bound, input string n);
        logic [31:0] d;
        int k;
        d = 32'd0;
        for (k = 0; k < bound; k++) begin
            apb_read(a, d);
            if ((d & mask) != 0) break;
        end
        vectors++;
        if ((d & mask) == 0) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h want bit(s) 0x%08h set within %0d reads", n, d, mask, bound);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        rx_man = 1'b0; cycles(48);
        for (int i = 0; i < 8; i++) begin
            rx_man = b[i]; cycles(48);
        end
        rx_man = stop_val; cycles(stop_val ? 48 : 36);
        rx_man = 1'b1; cycles(300);
    endtask

    task automatic measure_bits();
        int c;
        c = 0;
        @(negedge PCLK);
        while (TX !== 1'b0 && c < 400) begin
            @(negedge PCLK); c++;
        end
        chk("start_seen", int'(TX), 0);
        c = 0;
        while (TX === 1'b0 && c < 200) begin
            c++; @(negedge PCLK);
        end
        chk("start_bit_cycles", c, 48);
        c = 0;
        while (TX === 1'b1 && c < 200) begin
            c++; @(negedge PCLK);
        end
        chk("d0_bit_cycles", c, 48);
    endtask

    initial begin
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'd0; PWDATA = 32'd0; loop_en = 1'b1; rx_man = 1'b1;
        cycles(3);
        #1 PRESETn = 1'b1;
        cycles(3);

        // Reset state
        chk("reset_tx", int'(TX), 1);
        chk("reset_irq", int'(irq), 0);
        check_read(32'h004, 32'h0, 32'hFFFF_FFFF, "reset_prescale");
        check_read(32'h100, 32'h0, 32'hFFFF_FFFF, "reset_ctrl");
        check_read(32'h208, 32'h0, 32'hFFFF_FFFF, "reset_im");
        check_read(32'h200, 32'h12, 32'hFFFF_FFFF, "reset_ris");

        // Loopback burst
        apb_write(32'h004, 32'd2);
        apb_write(32'h100, 32'd0);
        apb_write(32'h208, 32'd0);
        apb_write(32'h20C, 32'hFF);
        apb_write(32'h00C, 32'd7);
        apb_write(32'h208, 32'h20);
        apb_write(32'h100, 32'd1);
        fork
            measure_bits();
            for (int i = 1; i <= 8; i++) apb_write(32'h000, 32'(i * 8'h11));
        join
        poll(32'h204, 32'h20, 5000, "mis_rx_thresh");
        check_read(32'h204, 32'h20, 32'hFFFF_FFFF, "mis_value");
        cycles(2);
        chk("irq_set", int'(irq), 1);

        // Interrupt clear while level still above threshold
        apb_write(32'h20C, 32'h20);
        check_read(32'h200, 32'h32, 32'hFFFF_FFFF, "ris_sticky_cond");
        for (int i = 1; i <= 8; i++)
            check_read(32'h000, 32'(i * 8'h11), 32'hFFFF_FFFF, "rx_burst_data");
        apb_write(32'h20C, 32'h20);
        check_read(32'h200, 32'h12, 32'hFFFF_FFFF, "ris_cleared");
        cycles(2);
        chk("irq_cleared", int'(irq), 0);

        // TX FIFO full
        apb_write(32'h100, 32'd0);
        apb_write(32'h20C, 32'h3F);
        for (int i = 0; i < 17; i++) apb_write(32'h000, 32'(8'hA0 + i));
        check_read(32'h200, 32'h01, 32'h01, "ris_tx_full");
        apb_write(32'h20C, 32'h3F);
        check_read(32'h200, 32'h00, 32'h02, "ris_tx_not_empty");
        apb_write(32'h100, 32'd1);
        poll(32'h200, 32'h02, 6000, "ris_tx_empty");
        cycles(700);
        check_read(32'h200, 32'h08, 32'h08, "ris_rx_full");
        for (int i = 0; i < 16; i++)
            check_read(32'h000, 32'(8'hA0 + i), 32'hFFFF_FFFF, "rx_txfull_data");
        check_read(32'h000, 32'h0, 32'hFFFF_FFFF, "rx_17th_absent");

        // RX overrun
        apb_write(32'h20C, 32'h3F);
        apb_write(32'h000, 32'hC0);
        cycles(10);
        for (int i = 1; i < 17; i++) apb_write(32'h000, 32'(8'hC0 + i));
        cycles(9000);
        check_read(32'h200, 32'h08, 32'h08, "ris_overrun_full");
        for (int i = 0; i < 16; i++)
            check_read(32'h000, 32'(8'hC0 + i), 32'hFFFF_FFFF, "rx_overrun_data");
        check_read(32'h000, 32'h0, 32'hFFFF_FFFF, "rx_overrun_dropped");

        // Glitch and framing error on a hand-driven line
        rx_man = 1'b1;
        loop_en = 1'b0;
        cycles(50);
        apb_write(32'h20C, 32'h3F);
        rx_man = 1'b0; cycles(12);
        rx_man = 1'b1; cycles(200);
        check_read(32'h000, 32'h0, 32'hFFFF_FFFF, "rx_glitch_ignored");
        send_frame(8'h55, 1'b0);
        check_read(32'h200, 32'h10, 32'h30, "ris_framing_rx_empty");
        check_read(32'h000, 32'h0, 32'hFFFF_FFFF, "rx_framing_discard");
        send_frame(8'h5A, 1'b1);
        check_read(32'h000, 32'h5A, 32'hFFFF_FFFF, "rx_manual_good");

        // Disable mid-frame
        loop_en = 1'b1;
        apb_write(32'h000, 32'h3C);
        cycles(100);
        apb_write(32'h100, 32'd0);
        cycles(2);
        chk("tx_idle_after_abort", int'(TX), 1);
        apb_write(32'h100, 32'd1);
        cycles(700);
        check_read(32'h000, 32'h0, 32'hFFFF_FFFF, "abort_byte_lost");

        cycles(5);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
